ibus_dbus_arbiter: RTL
======================

// Module: ibus_dbus_arbiter
// PURPOSE
// - Merges the core's instruction-fetch bus (I*) and data bus (D*) onto one external memory bus (M*).
// - Sits directly downstream of the CPU core wrapper's IADDR/DADDR ports, in front of the memory/interconnect.
// - Grants one master at a time and holds the grant until every beat of the granted transaction is ACKed.
// - Arbitration is round-robin between the two masters.
// PARAMETERS
// - AW           32  address width
// - DW           32  data width; strobe width is DW/8
// - BURST_BEATS  8   beats per INCR/WRAP burst (cache line); BURST=00 is 1 beat; must be >=2
// PORTS
// - clk                    in   1        core clock
// - rst                    in   1        asynchronous, active-high reset
// - IADDR/DADDR            in   AW       master address
// - IBURST/DBURST          in   2        00 normal, 01 INCR, 10 WRAP, 11 reserved (treated as 00)
// - IREQ/DREQ              in   1        beat request; held stable while stalled
// - IWRB/DWRB              in   1        1=write, 0=read
// - IWDATA/DWDATA          in   DW       write data
// - IBSTROBE/DBSTROBE      in   DW/8     byte strobes
// - IRDATA/DRDATA          out  DW       read data to master
// - IACK/DACK              out  1        beat complete to master
// - ISTALL/DSTALL          out  1        beat not accepted by master's view of the bus
// - MADDR/MBURST/MREQ/MWRB/MWDATA/MBSTROBE  out  as above  to memory
// - MRDATA                 in   DW       memory read data
// - MACK                   in   1        memory beat complete
// - MSTALL                 in   1        memory not accepting beat
// BEHAVIOUR
// - Handshake:
//   - A beat is accepted on a cycle with REQ=1 and STALL=0.
//   - ACK may arrive in the same cycle or later; beat data is valid when ACK=1.
// - FSM states IDLE, OWN_I, OWN_D; state and last_grant are registered.
// - IDLE:
//   - M outputs are all zero; ISTALL=DSTALL=1 when the matching REQ=1, else 0.
//   - Only IDREQ=1 -> OWN_D next cycle. Only IREQ=1 -> OWN_I next cycle.
//   - IREQ=1 and DREQ=1 together -> the master not in last_grant wins; reset value of last_grant is I, so D wins first.
//   - Arbitration latency is therefore 1 cycle: a request seen in IDLE reaches MREQ on the next cycle.
// - OWN_x:
//   - M* outputs are a combinational copy of master x's signals.
//   - xSTALL=MSTALL, xACK=MACK, xRDATA=MRDATA.
//   - The other master sees STALL=its REQ, ACK=0, RDATA=0.
// - Beat counter:
//   - Loaded on grant with 1 (BURST 00/11) or BURST_BEATS (01/10).
//   - Decrements on each MACK.
//   - MACK with count==1 -> IDLE next cycle; last_grant := x.
//   - MBURST is latched at grant; changes to x's BURST mid-transaction are ignored.
// - MACK while in IDLE is ignored and not forwarded.
// - Back-to-back requests:
//   - The winner of the next arbitration always has 1 idle cycle on M (IDLE state) between transactions.
//   - A master still holding REQ after its last ACK loses to a pending other master.
// - Reset:
//   - Asynchronous; mid-transaction reset forces IDLE with last_grant=I and count=0.
//   - All M outputs and I/D ACK/RDATA go to 0 immediately; the remaining beats are abandoned.
// - Counter width is $clog2(BURST_BEATS+1); no wrap can occur because it is never decremented at 0.
// STRUCTURE
// - Shared package (bus_pkg): BURST encodings (BURST_NORMAL, BURST_INCR, BURST_WRAP) and the state enum.
// - Single flat module; the round-robin pick is a small function, not a sub-module.
// TESTING
// - Single D read, BURST=00, MSTALL=0, MACK one cycle after MREQ -> DACK once; grant returns to IDLE, then free.
// - IREQ & DREQ asserted in the same cycle after reset:
//   - D serviced first with a WRAP burst (8 MACKs).
//   - I gets the grant 1 cycle after the 8th MACK.
//   - DSTALL=1 throughout I's turn if DREQ is reasserted.
// - I INCR burst with MSTALL=1 for 3 cycles on beat 1 -> ISTALL mirrors MSTALL; MADDR/MWDATA held; exactly 8 IACKs.
// - D write, DBSTROBE=4'b0011, DWDATA=32'hDEADBEEF -> MWRB=1, MBSTROBE=0011, MWDATA=DEADBEEF; IACK never asserted.
// - Async rst asserted after the 3rd MACK of an I burst -> same-cycle MREQ=0, IACK=0; state IDLE.
//   - The next DREQ is granted in 1 cycle.
// - Stray MACK in IDLE -> no IACK/DACK pulse.
// - IBURST=11 -> treated as a single beat.

Source files
------------

// File: rtl/ibus_dbus_arbiter_pkg.sv
// rtl/ibus_dbus_arbiter_pkg.sv - shared burst encodings, FSM states and round-robin pick
package ibus_dbus_arbiter_pkg;

    localparam logic [1:0] BURST_NORMAL = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_I = 2'd1;
    localparam logic [1:0] ST_OWN_D = 2'd2;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // On contention the master that did not own the bus last goes next.
    function automatic grant_e rr_pick(input logic ireq, input logic dreq, input grant_e last);
        if (ireq && dreq)
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        else if (dreq)
            return GRANT_D;
        else
            return GRANT_I;
    endfunction

    function automatic logic is_burst(input logic [1:0] burst);
        return (burst == BURST_INCR) || (burst == BURST_WRAP);
    endfunction

endpackage

// File: rtl/ibus_dbus_arbiter.sv
// rtl/ibus_dbus_arbiter.sv - round-robin merge of instruction and data buses onto one memory bus
module ibus_dbus_arbiter
    import ibus_dbus_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int BURST_BEATS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   IADDR,
    input  logic [1:0]      IBURST,
    input  logic            IREQ,
    input  logic            IWRB,
    input  logic [DW-1:0]   IWDATA,
    input  logic [DW/8-1:0] IBSTROBE,
    output logic [DW-1:0]   IRDATA,
    output logic            IACK,
    output logic            ISTALL,
    input  logic [AW-1:0]   DADDR,
    input  logic [1:0]      DBURST,
    input  logic            DREQ,
    input  logic            DWRB,
    input  logic [DW-1:0]   DWDATA,
    input  logic [DW/8-1:0] DBSTROBE,
    output logic [DW-1:0]   DRDATA,
    output logic            DACK,
    output logic            DSTALL,
    output logic [AW-1:0]   MADDR,
    output logic [1:0]      MBURST,
    output logic            MREQ,
    output logic            MWRB,
    output logic [DW-1:0]   MWDATA,
    output logic [DW/8-1:0] MBSTROBE,
    input  logic [DW-1:0]   MRDATA,
    input  logic            MACK,
    input  logic            MSTALL
);

    localparam int CW = $clog2(BURST_BEATS + 1);

    logic [1:0]    r_state;
    grant_e        r_last_grant;
    logic [CW-1:0] r_count;
    logic [1:0]    r_mburst;

    grant_e        w_pick;
    logic [1:0]    w_sel_burst;
    logic [CW-1:0] w_load;

    always_comb begin
        w_pick      = rr_pick(IREQ, DREQ, r_last_grant);
        w_sel_burst = (w_pick == GRANT_D) ? DBURST : IBURST;
        w_load      = is_burst(w_sel_burst) ? CW'(BURST_BEATS) : CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_I;
            r_count      <= '0;
            r_mburst     <= BURST_NORMAL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (IREQ || DREQ) begin
                        r_state  <= (w_pick == GRANT_D) ? ST_OWN_D : ST_OWN_I;
                        r_count  <= w_load;
                        // Reserved encoding 11 is presented downstream as a plain single beat.
                        r_mburst <= is_burst(w_sel_burst) ? w_sel_burst : BURST_NORMAL;
                    end
                end
                ST_OWN_I, ST_OWN_D: begin
                    if (MACK) begin
                        if (r_count == CW'(1)) begin
                            r_state      <= ST_IDLE;
                            r_last_grant <= (r_state == ST_OWN_D) ? GRANT_D : GRANT_I;
                            r_count      <= '0;
                        end else begin
                            r_count <= r_count - CW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        MADDR    = '0;
        MBURST   = BURST_NORMAL;
        MREQ     = 1'b0;
        MWRB     = 1'b0;
        MWDATA   = '0;
        MBSTROBE = '0;
        IRDATA   = '0;
        IACK     = 1'b0;
        ISTALL   = IREQ;
        DRDATA   = '0;
        DACK     = 1'b0;
        DSTALL   = DREQ;
        case (r_state)
            ST_OWN_I: begin
                MADDR    = IADDR;
                MBURST   = r_mburst;
                MREQ     = IREQ;
                MWRB     = IWRB;
                MWDATA   = IWDATA;
                MBSTROBE = IBSTROBE;
                IRDATA   = MRDATA;
                IACK     = MACK;
                ISTALL   = MSTALL;
            end
            ST_OWN_D: begin
                MADDR    = DADDR;
                MBURST   = r_mburst;
                MREQ     = DREQ;
                MWRB     = DWRB;
                MWDATA   = DWDATA;
                MBSTROBE = DBSTROBE;
                DRDATA   = MRDATA;
                DACK     = MACK;
                DSTALL   = MSTALL;
            end
            default: ;
        endcase
    end

endmodule
